alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 1: number of cycles operands are held on the ALU before the result is sampled; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 REQ_VALID  input  2  bit n set means requester n presents an operation.
REQ-005 REQ_READY  output  2  bit n set means requester n's operation is accepted this cycle.
REQ-006 REQ_INSTR  input  64  instruction word per requester; [31:0] belongs to requester 0 and [63:32] to requester 1.
REQ-007 REQ_RS  input  64  RS operand per requester, packed the same way as REQ_INSTR.
REQ-008 REQ_RT  input  64  RT operand per requester, packed the same way as REQ_INSTR.
REQ-009 OPCODE  output  6  registered drive to the ALU.
REQ-010 RS_VAL and RT_VAL  output  32 each  registered drives to the ALU.
REQ-011 SHAMT  output  5, FUNC  output  6, RAW_VAL  output  16  registered drives to the ALU.
REQ-012 ALU_RESULT  input  32, ALU_SIG_B  input  1  driven from the ALU's RESULT and SIG_B outputs.
REQ-013 RSP_VALID  output  1, RSP_ID  output  1, RSP_RESULT  output  32, RSP_SIG_B  output  1  registered response.
REQ-014 RSP_READY  input  1  the consumer accepts the response.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, EXEC and HOLD.
REQ-016 In IDLE with no REQ_VALID bit set, the block SHALL stay in IDLE and keep REQ_READY at 0.
REQ-017 In IDLE with one or more REQ_VALID bits set, the block SHALL grant exactly one requester.
- If both requesters are valid, the grant goes to the requester not granted last (round-robin via a LAST pointer).
- If one requester is valid, it is granted regardless of LAST.
REQ-018 REQ_READY SHALL be driven combinationally and only the granted bit may be 1, and only in IDLE; the handshake completes in that same cycle.
REQ-019 On a grant, the block SHALL register the following fields of the granted requester, update LAST and CNT, and enter EXEC:
- OPCODE = INSTR[31:26], SHAMT = INSTR[10:6], FUNC = INSTR[5:0], RAW_VAL = INSTR[15:0];
- RS_VAL and RT_VAL = that requester's RS and RT slices;
- RSP_ID = the granted index, LAST = the granted index, CNT = EXEC_CYCLES-1.
REQ-020 In EXEC with CNT nonzero, the block SHALL decrement CNT and stay in EXEC.
REQ-021 In EXEC with CNT equal to 0, the block SHALL capture ALU_RESULT into RSP_RESULT and ALU_SIG_B into RSP_SIG_B, set RSP_VALID, and enter HOLD.
REQ-022 ALU drive outputs SHALL hold stable from the grant edge until the block leaves HOLD.
REQ-023 In HOLD, RSP_VALID, RSP_ID, RSP_RESULT and RSP_SIG_B SHALL hold stable until RSP_READY is 1.
REQ-024 In HOLD with RSP_READY at 1, the block SHALL clear RSP_VALID and return to IDLE on that edge.
- A new grant is possible no earlier than the following cycle.
- Minimum issue interval is EXEC_CYCLES+2 cycles.
REQ-025 A request not granted SHALL NOT see REQ_READY; it is retried while REQ_VALID stays high, with no loss or duplication.
REQ-026 A REQ_VALID that drops while the block is in EXEC or HOLD SHALL have no effect.
REQ-027 The block SHALL perform no arithmetic; results pass from the ALU unmodified.

Reset
REQ-028 While RST is 1, regardless of CLK, the block SHALL force:
- state to IDLE, CNT to 0, LAST to 1 (requester 0 wins the first tie);
- REQ_READY to 0;
- all ALU drive outputs and all RSP_* outputs to 0.
REQ-029 A reset asserted in EXEC or HOLD SHALL abort the operation and emit no response.
- The requester's handshake has already completed, so the operation is lost, and the owning controller is responsible for that.

Verification
REQ-030 Requester 0 alone sends an ANDI (opcode 010010), RS=15, imm=19, EXEC_CYCLES=1, with RSP_READY held at 1 -> REQ_READY=01 in the grant cycle; RSP_VALID=1 two edges after the grant with RSP_ID=0 and RSP_RESULT=3; back in IDLE one edge later.
REQ-031 Both requesters are valid continuously out of reset, with ANDI 23&14 on requester 0 and ANDI 1&8 on requester 1 -> grants alternate 0,1,0,1; responses are 6 (ID 0), 0 (ID 1), and so on.
REQ-032 RSP_READY is held at 0 for 5 cycles in HOLD -> RSP_* stay constant; REQ_READY stays 00 despite both requests being valid; completion follows one edge after RSP_READY rises.
REQ-033 EXEC_CYCLES=4 -> OPCODE/RS_VAL/RT_VAL stay stable for 4 cycles; RSP_VALID rises 5 edges after the grant.
REQ-034 RST is pulsed mid-EXEC, asynchronously between edges -> all outputs read 0 immediately; no RSP_VALID follows; the next tie is won by requester 0.
REQ-035 Requester 1 only, then requester 0 only -> each is granted immediately; LAST does not block a lone requester.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared single-issue ALU.
// Ports: i_clk/i_rst; i_req_valid/o_req_ready/i_req_instr/i_req_rs/i_req_rt (two requesters,
//   32-bit lanes, [31:0] = requester 0); o_opcode/o_rs_val/o_rt_val/o_shamt/o_func/o_raw_val
//   drive the ALU; i_alu_result/i_alu_sig_b come back from it; o_rsp_* with i_rsp_ready return
//   the result.
// Latency: grant cycle, then EXEC_CYCLES cycles in EXEC, then HOLD until i_rsp_ready; one op in flight.
// Backpressure: o_req_ready is raised only in IDLE; HOLD stalls on i_rsp_ready.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [63:0] i_req_instr,
  input  logic [63:0] i_req_rs,
  input  logic [63:0] i_req_rt,
  output logic [5:0]  o_opcode,
  output logic [31:0] o_rs_val,
  output logic [31:0] o_rt_val,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_func,
  output logic [15:0] o_raw_val,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_sig_b,
  output logic        o_rsp_valid,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_result,
  output logic        o_rsp_sig_b,
  input  logic        i_rsp_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last;

  logic        w_gnt_vld;
  logic        w_gnt_idx;
  logic [31:0] w_instr;
  logic [31:0] w_rs;
  logic [31:0] w_rt;
  logic        w_unused;

  // On a tie the requester not served last wins; a lone requester always wins.
  assign w_gnt_idx = (&i_req_valid) ? ~r_last : i_req_valid[1];
  // Gated by i_rst so ready reads 0 while reset is held, even mid-cycle.
  assign w_gnt_vld = (r_state == IDLE) && (|i_req_valid) && !i_rst;
  assign o_req_ready = w_gnt_vld ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  assign w_instr = w_gnt_idx ? i_req_instr[63:32] : i_req_instr[31:0];
  assign w_rs    = w_gnt_idx ? i_req_rs[63:32]    : i_req_rs[31:0];
  assign w_rt    = w_gnt_idx ? i_req_rt[63:32]    : i_req_rt[31:0];

  // Instruction bits [25:16] (register specifiers) are not forwarded to the ALU.
  assign w_unused = ^w_instr[25:16];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_last       <= 1'b1;
      o_opcode     <= 6'd0;
      o_rs_val     <= 32'd0;
      o_rt_val     <= 32'd0;
      o_shamt      <= 5'd0;
      o_func       <= 6'd0;
      o_raw_val    <= 16'd0;
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= 1'b0;
      o_rsp_result <= 32'd0;
      o_rsp_sig_b  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            o_opcode  <= w_instr[31:26];
            o_shamt   <= w_instr[10:6];
            o_func    <= w_instr[5:0];
            o_raw_val <= w_instr[15:0];
            o_rs_val  <= w_rs;
            o_rt_val  <= w_rt;
            o_rsp_id  <= w_gnt_idx;
            r_last    <= w_gnt_idx;
            r_cnt     <= CNT_INIT;
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            o_rsp_result <= i_alu_result;
            o_rsp_sig_b  <= i_alu_sig_b;
            o_rsp_valid  <= 1'b1;
            r_state      <= HOLD;
          end
        end
        HOLD: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Instance A: EXEC_CYCLES = 1
  logic [1:0]  a_req_valid;
  logic [1:0]  a_req_ready;
  logic [63:0] a_req_instr, a_req_rs, a_req_rt;
  logic [5:0]  a_opcode, a_func;
  logic [31:0] a_rs_val, a_rt_val, a_rsp_result;
  logic [4:0]  a_shamt;
  logic [15:0] a_raw_val;
  logic        a_rsp_valid, a_rsp_id, a_rsp_sig_b, a_rsp_ready;
  logic [31:0] a_alu_result;
  logic        a_alu_sig_b;

  // Instance B: EXEC_CYCLES = 4
  logic [1:0]  b_req_valid;
  logic [1:0]  b_req_ready;
  logic [63:0] b_req_instr, b_req_rs, b_req_rt;
  logic [5:0]  b_opcode, b_func;
  logic [31:0] b_rs_val, b_rt_val, b_rsp_result;
  logic [4:0]  b_shamt;
  logic [15:0] b_raw_val;
  logic        b_rsp_valid, b_rsp_id, b_rsp_sig_b, b_rsp_ready;
  logic [31:0] b_alu_result;
  logic        b_alu_sig_b;

  // Behavioural ALU stand-in: ANDI with zero-extended immediate.
  assign a_alu_result = a_rs_val & {16'd0, a_raw_val};
  assign a_alu_sig_b  = a_rs_val[0];
  assign b_alu_result = b_rs_val & {16'd0, b_raw_val};
  assign b_alu_sig_b  = b_rs_val[0];

  alu_arbiter #(.EXEC_CYCLES(1)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
    .i_req_instr(a_req_instr), .i_req_rs(a_req_rs), .i_req_rt(a_req_rt),
    .o_opcode(a_opcode), .o_rs_val(a_rs_val), .o_rt_val(a_rt_val),
    .o_shamt(a_shamt), .o_func(a_func), .o_raw_val(a_raw_val),
    .i_alu_result(a_alu_result), .i_alu_sig_b(a_alu_sig_b),
    .o_rsp_valid(a_rsp_valid), .o_rsp_id(a_rsp_id),
    .o_rsp_result(a_rsp_result), .o_rsp_sig_b(a_rsp_sig_b),
    .i_rsp_ready(a_rsp_ready)
  );

  alu_arbiter #(.EXEC_CYCLES(4)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
    .i_req_instr(b_req_instr), .i_req_rs(b_req_rs), .i_req_rt(b_req_rt),
    .o_opcode(b_opcode), .o_rs_val(b_rs_val), .o_rt_val(b_rt_val),
    .o_shamt(b_shamt), .o_func(b_func), .o_raw_val(b_raw_val),
    .i_alu_result(b_alu_result), .i_alu_sig_b(b_alu_sig_b),
    .o_rsp_valid(b_rsp_valid), .o_rsp_id(b_rsp_id),
    .o_rsp_result(b_rsp_result), .o_rsp_sig_b(b_rsp_sig_b),
    .i_rsp_ready(b_rsp_ready)
  );

  function automatic logic [31:0] andi(input logic [15:0] imm);
    return {6'b010010, 10'd0, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_req_valid = 2'b00; a_req_instr = '0; a_req_rs = '0; a_req_rt = '0; a_rsp_ready = 1'b0;
    b_req_valid = 2'b00; b_req_instr = '0; b_req_rs = '0; b_req_rt = '0; b_rsp_ready = 1'b0;

    // Reset state, with requests present while reset is held
    #1 rst = 1'b1;
    a_req_valid = 2'b11;
    #1;
    chk("rst_ready",   {30'd0, a_req_ready}, 32'd0);
    chk("rst_rsp_vld", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_opcode",  {26'd0, a_opcode},    32'd0);
    chk("rst_rs_val",  a_rs_val,             32'd0);
    chk("rst_result",  a_rsp_result,         32'd0);
    a_req_valid = 2'b00;
    tick(); tick();
    #3 rst = 1'b0;
    tick();

    // Lone requester 0, ANDI 15 & 19
    a_req_instr[31:0] = andi(16'd19);
    a_req_rs[31:0]    = 32'd15;
    a_req_valid       = 2'b01;
    a_rsp_ready       = 1'b1;
    #1;
    chk("andi_ready", {30'd0, a_req_ready}, 32'd1);
    tick();
    a_req_valid = 2'b00;          // drop during EXEC: must be ignored
    chk("andi_opcode", {26'd0, a_opcode},  32'h12);
    chk("andi_raw",    {16'd0, a_raw_val}, 32'd19);
    chk("andi_func",   {26'd0, a_func},    32'd19);
    chk("andi_shamt",  {27'd0, a_shamt},   32'd0);
    chk("andi_rs",     a_rs_val,           32'd15);
    chk("andi_vld_e1", {31'd0, a_rsp_valid}, 32'd0);
    tick();
    chk("andi_vld",    {31'd0, a_rsp_valid}, 32'd1);
    chk("andi_id",     {31'd0, a_rsp_id},    32'd0);
    chk("andi_result", a_rsp_result,         32'd3);
    chk("andi_sigb",   {31'd0, a_rsp_sig_b}, 32'd1);
    tick();
    chk("andi_done",   {31'd0, a_rsp_valid}, 32'd0);
    chk("andi_idle_rdy", {30'd0, a_req_ready}, 32'd0);

    // Fresh reset so LAST starts at 1, then both valid continuously
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    a_req_instr = {andi(16'd8), andi(16'd14)};
    a_req_rs    = {32'd1, 32'd23};
    a_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready", {30'd0, a_req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      tick();
      chk("rr_vld",    {31'd0, a_rsp_valid}, 32'd1);
      chk("rr_id",     {31'd0, a_rsp_id},    (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_result", a_rsp_result,         (k % 2 == 0) ? 32'd6 : 32'd0);
      tick();
    end

    // Stall in HOLD for 5 cycles; requester 0 wins (LAST=1)
    a_rsp_ready = 1'b0;
    #1;
    chk("stall_grant", {30'd0, a_req_ready}, 32'd1);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_vld",    {31'd0, a_rsp_valid}, 32'd1);
      chk("stall_result", a_rsp_result,         32'd6);
      chk("stall_id",     {31'd0, a_rsp_id},    32'd0);
      chk("stall_ready",  {30'd0, a_req_ready}, 32'd0);
      chk("stall_opcode", {26'd0, a_opcode},    32'h12);
      tick();
    end
    a_rsp_ready = 1'b1;
    #1;
    chk("stall_still", {31'd0, a_rsp_valid}, 32'd1);
    tick();
    chk("stall_done",  {31'd0, a_rsp_valid}, 32'd0);
    chk("stall_next",  {30'd0, a_req_ready}, 32'd2);

    // Lone requesters: 1, then 0, then 0 again (LAST=0 must not block it)
    a_req_valid = 2'b10;
    #1;
    chk("lone1_ready", {30'd0, a_req_ready}, 32'd2);
    tick(); tick();
    chk("lone1_id", {31'd0, a_rsp_id}, 32'd1);
    tick();
    for (int k = 0; k < 2; k++) begin
      a_req_valid = 2'b01;
      #1;
      chk("lone0_ready", {30'd0, a_req_ready}, 32'd1);
      tick(); tick();
      chk("lone0_id",     {31'd0, a_rsp_id}, 32'd0);
      chk("lone0_result", a_rsp_result,      32'd6);
      tick();
    end

    // Reset pulse mid-EXEC (requester 1 granted since LAST=0)
    a_req_valid = 2'b11;
    #1;
    chk("abort_grant", {30'd0, a_req_ready}, 32'd2);
    tick();
    a_req_valid = 2'b00;
    #2 rst = 1'b1;
    #1;
    chk("abort_opcode", {26'd0, a_opcode},    32'd0);
    chk("abort_rs",     a_rs_val,             32'd0);
    chk("abort_rsp",    {31'd0, a_rsp_valid}, 32'd0);
    chk("abort_id",     {31'd0, a_rsp_id},    32'd0);
    chk("abort_raw",    {16'd0, a_raw_val},   32'd0);
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_rsp", {31'd0, a_rsp_valid}, 32'd0);
    end
    a_req_valid = 2'b11;
    #1;
    chk("abort_tie", {30'd0, a_req_ready}, 32'd1);
    a_req_valid = 2'b00;
    tick();

    // EXEC_CYCLES = 4 on instance B
    b_req_instr[31:0] = andi(16'h00F0);
    b_req_rs[31:0]    = 32'h0000_0FFF;
    b_req_rt[31:0]    = 32'd77;
    b_req_valid       = 2'b01;
    b_rsp_ready       = 1'b1;
    #1;
    chk("ex4_ready", {30'd0, b_req_ready}, 32'd1);
    tick();
    b_req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      chk("ex4_vld_low", {31'd0, b_rsp_valid}, 32'd0);
      chk("ex4_opcode",  {26'd0, b_opcode},    32'h12);
      chk("ex4_rs",      b_rs_val,             32'h0000_0FFF);
      chk("ex4_rt",      b_rt_val,             32'd77);
      tick();
    end
    chk("ex4_vld",    {31'd0, b_rsp_valid}, 32'd1);
    chk("ex4_result", b_rsp_result,         32'h0000_00F0);
    tick();
    chk("ex4_done",   {31'd0, b_rsp_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
